// File: rtl/vxe_mem_hub_cu_us_if.sv
// CU upstream request bus of the VxE memory hub: CU header/data queues in, two master queues out.
// The hub side uses the slave modport; whoever drives the CU queues and master readies uses master.
`timescale 1ns/1ps
interface vxe_mem_hub_cu_us_if;
  logic        i_rqa_vld;
  logic [43:0] i_rqa;
  logic        o_rqa_rd;
  logic        i_rqd_vld;
  logic [71:0] i_rqd;
  logic        o_rqd_rd;
  logic        i_m0_rqa_rdy;
  logic [43:0] o_m0_rqa;
  logic        o_m0_rqa_wr;
  logic        i_m0_rqd_rdy;
  logic [71:0] o_m0_rqd;
  logic        o_m0_rqd_wr;
  logic        i_m1_rqa_rdy;
  logic [43:0] o_m1_rqa;
  logic        o_m1_rqa_wr;
  logic        i_m1_rqd_rdy;
  logic [71:0] o_m1_rqd;
  logic        o_m1_rqd_wr;

  modport slave (
    input  i_rqa_vld, i_rqa, i_rqd_vld, i_rqd,
    input  i_m0_rqa_rdy, i_m0_rqd_rdy, i_m1_rqa_rdy, i_m1_rqd_rdy,
    output o_rqa_rd, o_rqd_rd,
    output o_m0_rqa, o_m0_rqa_wr, o_m0_rqd, o_m0_rqd_wr,
    output o_m1_rqa, o_m1_rqa_wr, o_m1_rqd, o_m1_rqd_wr
  );

  modport master (
    output i_rqa_vld, i_rqa, i_rqd_vld, i_rqd,
    output i_m0_rqa_rdy, i_m0_rqd_rdy, i_m1_rqa_rdy, i_m1_rqd_rdy,
    input  o_rqa_rd, o_rqd_rd,
    input  o_m0_rqa, o_m0_rqa_wr, o_m0_rqd, o_m0_rqd_wr,
    input  o_m1_rqa, o_m1_rqa_wr, o_m1_rqd, o_m1_rqd_wr
  );
endinterface

// File: rtl/vxe_mem_hub_cu_us.sv
// CU upstream request router: routes headers by address bit MSEL_BIT and keeps write data on its
// header's master via an in-order destination FIFO. VXE_MEM_HUB_CU_US_CNT_EN adds push counters.
`timescale 1ns/1ps
module vxe_mem_hub_cu_us #(
  parameter int unsigned MSEL_BIT   = 36,
  parameter int unsigned WORD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
`ifdef VXE_MEM_HUB_CU_US_CNT_EN
  input  logic        i_cnt_clr,
  output logic [15:0] o_m0_cnt,
  output logic [15:0] o_m1_cnt,
`endif
  vxe_mem_hub_cu_us_if.slave bus
);

  localparam int unsigned AW = $clog2(WORD_DEPTH);

  logic [43:0]           hdr_q, hdr_d;
  logic                  hdr_full_q, hdr_full_d;
  logic [71:0]           dat_q, dat_d;
  logic                  dat_full_q, dat_full_d;
  logic [WORD_DEPTH-1:0] ord_mem_q, ord_mem_d;
  logic [AW:0]           ord_wptr_q, ord_wptr_d;
  logic [AW:0]           ord_rptr_q, ord_rptr_d;

  logic        hdr_dst, hdr_push, rqa_rd, rqa_is_wr;
  logic        m0_hdr_wr, m1_hdr_wr;
  logic        dat_dst, dat_push, rqd_rd;
  logic        ord_full, ord_push, ord_pop, ord_avail;
  logic [AW:0] ord_cnt;

  assign hdr_dst   = hdr_q[MSEL_BIT];
  assign m0_hdr_wr = hdr_full_q & ~hdr_dst & bus.i_m0_rqa_rdy;
  assign m1_hdr_wr = hdr_full_q & hdr_dst & bus.i_m1_rqa_rdy;
  assign hdr_push  = m0_hdr_wr | m1_hdr_wr;
  assign rqa_is_wr = ~bus.i_rqa[37];

  assign ord_cnt  = ord_wptr_q - ord_rptr_q;
  assign ord_full = (ord_wptr_q[AW] != ord_rptr_q[AW]) &&
                    (ord_wptr_q[AW-1:0] == ord_rptr_q[AW-1:0]);
  // The head entry is already bound once the data holding register is full.
  assign ord_avail = ord_cnt > {{AW{1'b0}}, dat_full_q};
  assign dat_dst   = ord_mem_q[ord_rptr_q[AW-1:0]];
  assign dat_push  = dat_full_q & (dat_dst ? bus.i_m1_rqd_rdy : bus.i_m0_rqd_rdy);
  assign ord_pop   = dat_push;

  // Gated by nrst so pops are suppressed for the whole reset window, not just after the edge.
  assign rqa_rd   = nrst & bus.i_rqa_vld & (~hdr_full_q | hdr_push) &
                    ~(rqa_is_wr & ord_full & ~ord_pop);
  assign rqd_rd   = nrst & bus.i_rqd_vld & ord_avail & (~dat_full_q | dat_push);
  assign ord_push = rqa_rd & rqa_is_wr;

  assign bus.o_rqa_rd    = rqa_rd;
  assign bus.o_rqd_rd    = rqd_rd;
  assign bus.o_m0_rqa    = hdr_q;
  assign bus.o_m1_rqa    = hdr_q;
  assign bus.o_m0_rqa_wr = m0_hdr_wr;
  assign bus.o_m1_rqa_wr = m1_hdr_wr;
  assign bus.o_m0_rqd    = dat_q;
  assign bus.o_m1_rqd    = dat_q;
  assign bus.o_m0_rqd_wr = dat_push & ~dat_dst;
  assign bus.o_m1_rqd_wr = dat_push & dat_dst;

  always_comb begin
    hdr_d      = hdr_q;
    hdr_full_d = hdr_full_q;
    dat_d      = dat_q;
    dat_full_d = dat_full_q;
    ord_mem_d  = ord_mem_q;
    if (rqa_rd) begin
      hdr_d      = bus.i_rqa;
      hdr_full_d = 1'b1;
    end else if (hdr_push) begin
      hdr_full_d = 1'b0;
    end
    if (rqd_rd) begin
      dat_d      = bus.i_rqd;
      dat_full_d = 1'b1;
    end else if (dat_push) begin
      dat_full_d = 1'b0;
    end
    if (ord_push) begin
      ord_mem_d[ord_wptr_q[AW-1:0]] = bus.i_rqa[MSEL_BIT];
    end
    ord_wptr_d = ord_wptr_q + {{AW{1'b0}}, ord_push};
    ord_rptr_d = ord_rptr_q + {{AW{1'b0}}, ord_pop};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hdr_q      <= '0;
      hdr_full_q <= 1'b0;
      dat_q      <= '0;
      dat_full_q <= 1'b0;
      ord_mem_q  <= '0;
      ord_wptr_q <= '0;
      ord_rptr_q <= '0;
    end else begin
      hdr_q      <= hdr_d;
      hdr_full_q <= hdr_full_d;
      dat_q      <= dat_d;
      dat_full_q <= dat_full_d;
      ord_mem_q  <= ord_mem_d;
      ord_wptr_q <= ord_wptr_d;
      ord_rptr_q <= ord_rptr_d;
    end
  end

`ifdef VXE_MEM_HUB_CU_US_CNT_EN
  logic [15:0] m0_cnt_q, m0_cnt_d, m1_cnt_q, m1_cnt_d;

  always_comb begin
    m0_cnt_d = m0_cnt_q;
    m1_cnt_d = m1_cnt_q;
    if (i_cnt_clr) begin
      m0_cnt_d = '0;
      m1_cnt_d = '0;
    end else begin
      if (m0_hdr_wr && (m0_cnt_q != 16'hFFFF)) m0_cnt_d = m0_cnt_q + 16'd1;
      if (m1_hdr_wr && (m1_cnt_q != 16'hFFFF)) m1_cnt_d = m1_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m0_cnt_q <= '0;
      m1_cnt_q <= '0;
    end else begin
      m0_cnt_q <= m0_cnt_d;
      m1_cnt_q <= m1_cnt_d;
    end
  end

  assign o_m0_cnt = m0_cnt_q;
  assign o_m1_cnt = m1_cnt_q;
`endif

endmodule
